// File: rtl/mrc_desc_proc.sv
// mrc_desc_proc: memory-read-controller descriptor processor.
// Multi-beat MR descriptors arrive from the WU decoder, pass through a
// one-stage input register into a beat FIFO, and are assembled by a decode
// FSM that issues one read request per line to the memory-access side.
// Optional build macro: MRC_DESC_PROC_PROTOCOL_CHECK_EN turns framing,
// channel-range and unknown-option violations into a sticky error state.
// Without it those cases are tolerated and only FIFO overflow flags an error.

module mrc_desc_proc #(
    parameter int NUM_OPT        = 3,
    parameter int OPT_TYPE_W     = 8,
    parameter int OPT_VALUE_W    = 32,
    parameter int ADDR_W         = 24,
    parameter int NUM_CH         = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_THRESHOLD = 3
) (
    input  logic                                          clk,
    input  logic                                          reset_poweron,
    input  logic                                          wud__mrc__valid,
    output logic                                          mrc__wud__ready,
    input  logic [1:0]                                    wud__mrc__cntl,
    input  logic [NUM_OPT*OPT_TYPE_W-1:0]                 wud__mrc__option_type,
    input  logic [NUM_OPT*OPT_VALUE_W-1:0]                wud__mrc__option_value,
    output logic                                          mrc__mem__req_valid,
    input  logic                                          mem__mrc__req_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] mrc__mem__req_chan,
    output logic [ADDR_W-1:0]                             mrc__mem__req_addr,
    output logic                                          mrc__mem__req_last,
    output logic                                          mrc__desc_done,
    output logic                                          mrc__err
);

    localparam int CHAN_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LINES_W = 16;
    localparam int TYPES_W = NUM_OPT * OPT_TYPE_W;
    localparam int VALUES_W = NUM_OPT * OPT_VALUE_W;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(FIFO_DEPTH - FIFO_THRESHOLD);

    // Beat framing codes
    localparam logic [1:0] CNTL_SOM     = 2'd0;
    localparam logic [1:0] CNTL_MOM     = 2'd1;
    localparam logic [1:0] CNTL_EOM     = 2'd2;
    localparam logic [1:0] CNTL_SOM_EOM = 2'd3;

    // Option type codes
    localparam logic [OPT_TYPE_W-1:0] OPT_NOP    = OPT_TYPE_W'(0);
    localparam logic [OPT_TYPE_W-1:0] OPT_CHAN   = OPT_TYPE_W'(1);
    localparam logic [OPT_TYPE_W-1:0] OPT_ADDR   = OPT_TYPE_W'(2);
    localparam logic [OPT_TYPE_W-1:0] OPT_LINES  = OPT_TYPE_W'(3);
    localparam logic [OPT_TYPE_W-1:0] OPT_STRIDE = OPT_TYPE_W'(4);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    // Input register stage
    logic                inValid_q;
    logic [1:0]          inCntl_q;
    logic [TYPES_W-1:0]  inType_q;
    logic [VALUES_W-1:0] inValue_q;

    // Beat FIFO
    logic [1:0]          fifoCntl_q  [FIFO_DEPTH];
    logic [TYPES_W-1:0]  fifoType_q  [FIFO_DEPTH];
    logic [VALUES_W-1:0] fifoValue_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                fifoEmpty, fifoFull, fifoPush, fifoPop, overflow;
    logic                ready_q;

    logic [1:0]          headCntl;
    logic [TYPES_W-1:0]  headType;
    logic [VALUES_W-1:0] headValue;

    // Decode of the FIFO head beat against the descriptor being assembled
    logic                isStart, isEnd, protoErr;
    logic [CHAN_W-1:0]   newChan;
    logic [ADDR_W-1:0]   newAddr;
    logic [LINES_W-1:0]  newLines;
    logic [ADDR_W-1:0]   newStride;

    // Descriptor / request state
    state_t              state_q, state_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [LINES_W-1:0]  remain_q, remain_d;
    logic                open_q, open_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                unusedBits;

    // Capture every upstream beat once; ready is registered so upstream never overruns.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            inValid_q <= 1'b0;
            inCntl_q  <= 2'd0;
            inType_q  <= '0;
            inValue_q <= '0;
        end else begin
            inValid_q <= wud__mrc__valid;
            inCntl_q  <= wud__mrc__cntl;
            inType_q  <= wud__mrc__option_type;
            inValue_q <= wud__mrc__option_value;
        end
    end

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == DEPTH_CNT);
    // A pop in the same cycle frees the slot, so a write at full is legal then.
    assign fifoPush  = inValid_q && (!fifoFull || fifoPop);
    assign overflow  = inValid_q && fifoFull && !fifoPop;

    assign headCntl  = fifoCntl_q[rdPtr_q];
    assign headType  = fifoType_q[rdPtr_q];
    assign headValue = fifoValue_q[rdPtr_q];

    // Pointer and occupancy bookkeeping for the beat FIFO.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (fifoPush) begin
            wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PTR_W'(1);
        end
        if (fifoPop) begin
            rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PTR_W'(1);
        end
        if (fifoPush && !fifoPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!fifoPush && fifoPop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (fifoPush) begin
            fifoCntl_q[wrPtr_q]  <= inCntl_q;
            fifoType_q[wrPtr_q]  <= inType_q;
            fifoValue_q[wrPtr_q] <= inValue_q;
        end
    end

    // FIFO pointers, occupancy and the registered ready derived from next occupancy.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            ready_q <= (count_d < READY_LIMIT);
        end
    end

    // Fold the head beat's options, in index order, onto either defaults or the open descriptor.
    always_comb begin
        isStart  = (headCntl == CNTL_SOM) || (headCntl == CNTL_SOM_EOM);
        isEnd    = (headCntl == CNTL_EOM) || (headCntl == CNTL_SOM_EOM);
        protoErr = 1'b0;
`ifdef MRC_DESC_PROC_PROTOCOL_CHECK_EN
        // A start must open a closed descriptor; a continuation needs an open one.
        if (isStart == open_q) begin
            protoErr = 1'b1;
        end
`else
        // Orphan MOM/EOM behave as SOM/SOM_EOM; a SOM while open simply restarts.
        isStart = isStart || !open_q;
`endif
        if (isStart) begin
            newChan   = '0;
            newAddr   = '0;
            newLines  = LINES_W'(1);
            newStride = ADDR_W'(1);
        end else begin
            newChan   = chan_q;
            newAddr   = addr_q;
            newLines  = remain_q;
            newStride = stride_q;
        end
        for (int i = 0; i < NUM_OPT; i++) begin
            case (headType[i*OPT_TYPE_W +: OPT_TYPE_W])
                OPT_NOP: begin
                end
                OPT_CHAN: begin
`ifdef MRC_DESC_PROC_PROTOCOL_CHECK_EN
                    if (headValue[i*OPT_VALUE_W +: OPT_VALUE_W] >= OPT_VALUE_W'(NUM_CH)) begin
                        protoErr = 1'b1;
                    end
                    newChan = headValue[i*OPT_VALUE_W +: CHAN_W];
`else
                    newChan = CHAN_W'(32'(headValue[i*OPT_VALUE_W +: CHAN_W]) % NUM_CH);
`endif
                end
                OPT_ADDR: begin
                    newAddr = headValue[i*OPT_VALUE_W +: ADDR_W];
                end
                OPT_LINES: begin
                    newLines = headValue[i*OPT_VALUE_W +: LINES_W];
                end
                OPT_STRIDE: begin
                    newStride = headValue[i*OPT_VALUE_W +: ADDR_W];
                end
                default: begin
`ifdef MRC_DESC_PROC_PROTOCOL_CHECK_EN
                    protoErr = 1'b1;
`endif
                end
            endcase
        end
    end

    // Upper option value bits beyond the decoded fields carry no meaning.
    assign unusedBits = ^headValue;

    // Decode FSM: assemble descriptors in WAIT, stream line requests in ISSUE.
    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        remain_d = remain_q;
        open_d   = open_q;
        done_d   = 1'b0;
        err_d    = err_q || overflow;
        fifoPop  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    if (protoErr) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        open_d  = 1'b0;
                    end else begin
                        chan_d   = newChan;
                        addr_d   = newAddr;
                        stride_d = newStride;
                        remain_d = newLines;
                        if (isEnd) begin
                            open_d = 1'b0;
                            if (newLines == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = ST_ISSUE;
                            end
                        end else begin
                            open_d = 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (mem__mrc__req_ready) begin
                    addr_d   = addr_q + stride_q;
                    remain_d = remain_q - LINES_W'(1);
                    if (remain_q == LINES_W'(1)) begin
                        state_d = ST_WAIT;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_ERR: begin
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Descriptor registers and FSM state; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_q  <= ST_WAIT;
            chan_q   <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            remain_q <= '0;
            open_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            remain_q <= remain_d;
            open_q   <= open_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign mrc__wud__ready     = ready_q;
    assign mrc__mem__req_valid = (state_q == ST_ISSUE);
    assign mrc__mem__req_chan  = chan_q;
    assign mrc__mem__req_addr  = addr_q;
    assign mrc__mem__req_last  = (state_q == ST_ISSUE) && (remain_q == LINES_W'(1));
    assign mrc__desc_done      = done_q;
    assign mrc__err            = err_q;

endmodule
